// File: rtl/cbc_sequencer_if.sv
// Purpose : bundles the block-in, result-out and cipher-datapath signals of cbc_sequencer.
// Latency : n/a (wiring only).
// Backpres: in_valid/in_ready and out_valid/out_ready are plain valid-ready pairs.
//
// Port summary (slave = sequencer view):
//   block in  : in_valid, in_ready, in_block[127:0], key[127:0], EnDe, iv[127:0], iv_load
//   result out: out_valid, out_ready, out_block[127:0]
//   datapath  : dp_Reset, dp_Start, dp_EnDe, dp_block[127:0], dp_key[127:0] (to cipher),
//               dp_o[127:0], dp_busy (from cipher)
interface cbc_sequencer_if;
    // block input side
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] key;
    logic         EnDe;
    logic [127:0] iv;
    logic         iv_load;

    // result side
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    // cipher datapath side
    logic         dp_Reset;
    logic         dp_Start;
    logic         dp_EnDe;
    logic [127:0] dp_block;
    logic [127:0] dp_key;
    logic [127:0] dp_o;
    logic         dp_busy;

    modport slave (
        input  in_valid, in_block, key, EnDe, iv, iv_load,
        input  out_ready,
        input  dp_o, dp_busy,
        output in_ready,
        output out_valid, out_block,
        output dp_Reset, dp_Start, dp_EnDe, dp_block, dp_key
    );

    modport master (
        output in_valid, in_block, key, EnDe, iv, iv_load,
        output out_ready,
        output dp_o, dp_busy,
        input  in_ready,
        input  out_valid, out_block,
        input  dp_Reset, dp_Start, dp_EnDe, dp_block, dp_key
    );
endinterface

// File: rtl/cbc_sequencer.sv
// Purpose : sequences one 128-bit block at a time through an external cipher datapath, ECB or CBC.
// Latency : input transfer to out_valid = datapath busy cycles + 4 (one block in flight at most).
// Backpres: in_ready only in IDLE; result held in OUT until out_ready, indefinitely.
//
// Ports:
//   Clk   - clock, all state updates on the rising edge
//   Reset - synchronous active-high reset, clears all state
//   bus   - cbc_sequencer_if.slave: block input handshake, result handshake, datapath controls
//
// Build option: define CBC_MODE_EN for CBC chaining (chain register, iv/iv_load active).
// Without it the block runs in ECB mode and iv/iv_load are ignored.
module cbc_sequencer (
    input  logic           Clk,
    input  logic           Reset,
    cbc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DP_RST = 3'd1,
        S_DP_GO  = 3'd2,
        S_WAIT   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    // WAIT cycles without any busy before the first idle cycle is taken as completion
    localparam logic [7:0] WD_LIMIT = 8'd16;

    state_t       state;
    state_t       state_nxt;

    // latched per-block operands; they drive the datapath from DP_RST until leaving WAIT
    logic [127:0] dp_block_q;
    logic [127:0] key_q;
    logic         ende_q;

    logic [127:0] out_block_q;
    logic         seen_busy;
    logic [7:0]   wd_cnt;

    // combinational controls
    logic         in_ready_c;
    logic         out_valid_c;
    logic         dp_start_c;
    logic         dp_reset_c;
    logic         xfer;
    logic         done;
    logic         wd_expired;
    logic         iv_hit;

    logic [127:0] dp_block_nxt;
    logic [127:0] result_c;

`ifdef CBC_MODE_EN
    logic [127:0] chain;
    logic [127:0] blk_q;     // raw input block, becomes the chain value after a decrypt

    // iv_load only acts in IDLE and takes priority over an input transfer there
    assign iv_hit = bus.iv_load && (state == S_IDLE);

    // encrypt chains before the cipher, decrypt chains after it
    assign dp_block_nxt = bus.EnDe ? bus.in_block : (bus.in_block ^ chain);
    assign result_c     = ende_q ? (bus.dp_o ^ chain) : bus.dp_o;
`else
    logic unused_ecb;

    assign iv_hit       = 1'b0;
    assign dp_block_nxt = bus.in_block;
    assign result_c     = bus.dp_o;

    // the IV has no role in ECB; fold it into a sink so it is visibly consumed
    assign unused_ecb   = ^{bus.iv, bus.iv_load};
`endif

    assign wd_expired = (wd_cnt >= WD_LIMIT);

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        dp_start_c  = 1'b0;
        dp_reset_c  = Reset;     // the datapath is also held in reset during our own reset cycle
        xfer        = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                in_ready_c = !iv_hit;
                xfer       = bus.in_valid && in_ready_c;
                if (xfer) begin
                    state_nxt = S_DP_RST;
                end
            end

            S_DP_RST: begin
                dp_reset_c = 1'b1;
                state_nxt  = S_DP_GO;
            end

            S_DP_GO: begin
                dp_start_c = 1'b1;
                state_nxt  = S_WAIT;
            end

            S_WAIT: begin
                // a datapath that never raises busy is released by the watchdog
                done = !bus.dp_busy && (seen_busy || wd_expired);
                if (done) begin
                    state_nxt = S_OUT;
                end
            end

            S_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // operand latch, WAIT tracking and result register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dp_block_q  <= '0;
            key_q       <= '0;
            ende_q      <= 1'b0;
            out_block_q <= '0;
            seen_busy   <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            if (xfer) begin
                dp_block_q <= dp_block_nxt;
                key_q      <= bus.key;
                ende_q     <= bus.EnDe;
            end

            // WAIT always starts from a clean busy history and watchdog
            if (state == S_DP_GO) begin
                seen_busy <= 1'b0;
                wd_cnt    <= '0;
            end else if ((state == S_WAIT) && !done) begin
                if (bus.dp_busy) begin
                    seen_busy <= 1'b1;
                end
                if (wd_cnt != 8'hFF) begin
                    wd_cnt <= wd_cnt + 8'd1;
                end
            end

            if (done) begin
                out_block_q <= result_c;
            end
        end
    end

`ifdef CBC_MODE_EN
    // chain only moves on a completed block or an IV load; an aborted block leaves no trace
    always_ff @(posedge Clk) begin
        if (Reset) begin
            chain <= '0;
            blk_q <= '0;
        end else begin
            if (xfer) begin
                blk_q <= bus.in_block;
            end
            if (iv_hit) begin
                chain <= bus.iv;
            end else if (done) begin
                chain <= ende_q ? blk_q : bus.dp_o;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_block = out_block_q;
    assign bus.dp_Reset  = dp_reset_c;
    assign bus.dp_Start  = dp_start_c;
    assign bus.dp_EnDe   = ende_q;
    assign bus.dp_block  = dp_block_q;
    assign bus.dp_key    = key_q;

endmodule

// File: tb/tb_cbc_sequencer.sv
// Purpose : self-checking bench for cbc_sequencer with a stub cipher (o = block ^ key).
// Latency : stub raises busy one cycle after it samples Start and holds it for 10 cycles.
// Backpres: the bench stalls out_ready for random and long periods.
module tb_cbc_sequencer;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    cbc_sequencer_if bus();

    cbc_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // ---------------- datapath stub ----------------
    logic        stub_dead = 1'b0;   // when set the stub never reports busy
    logic        start_q   = 1'b0;
    logic        stub_busy = 1'b0;
    int unsigned busy_left = 0;

    always @(posedge Clk) begin
        if (bus.dp_Reset) begin
            start_q   <= 1'b0;
            stub_busy <= 1'b0;
            busy_left <= 0;
        end else begin
            start_q <= bus.dp_Start;
            if (start_q && !stub_dead) begin
                stub_busy <= 1'b1;
                busy_left <= 9;
            end else if (stub_busy) begin
                if (busy_left == 0) stub_busy <= 1'b0;
                else                busy_left <= busy_left - 1;
            end
        end
    end

    assign bus.dp_busy = stub_busy;
    assign bus.dp_o    = bus.dp_block ^ bus.dp_key;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] m_chain = '0;

    function automatic logic [127:0] cipher(input logic [127:0] x, input logic [127:0] k);
        return x ^ k;
    endfunction

    // C_i = E(P_i ^ C_{i-1});  P_i = D(C_i) ^ C_{i-1}
    task automatic model_step(input logic [127:0] blk, input logic [127:0] k, input logic ed,
                              output logic [127:0] exp_dp, output logic [127:0] exp_out);
`ifdef CBC_MODE_EN
        if (!ed) begin
            exp_dp  = blk ^ m_chain;
            exp_out = cipher(exp_dp, k);
            m_chain = exp_out;
        end else begin
            exp_dp  = blk;
            exp_out = cipher(blk, k) ^ m_chain;
            m_chain = blk;
        end
`else
        exp_dp  = blk;
        exp_out = cipher(blk, k);
`endif
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // drive one block, follow it through the datapath and collect the result.
    // Entry and exit: #1 after a rising edge with the DUT in IDLE.
    task automatic run_block(input logic [127:0] blk, input logic [127:0] k, input logic ed,
                             input int hold, input int exp_lat, input string tag,
                             output logic [127:0] got);
        logic [127:0] exp_dp;
        logic [127:0] exp_out;
        int lat;
        int n_start;
        int n_rst;
        model_step(blk, k, ed, exp_dp, exp_out);
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.key      = k;
        bus.EnDe     = ed;
        #1;
        check({tag, "/in_ready_idle"}, bus.in_ready, 1'b1);
        @(posedge Clk); #1;
        // scramble the inputs: the block in flight must not notice
        bus.in_valid = 1'b0;
        bus.in_block = rnd128();
        bus.key      = rnd128();
        bus.EnDe     = ~ed;
        lat     = 0;
        n_start = 0;
        n_rst   = 0;
        while (!bus.out_valid && lat < 60) begin
            if (bus.dp_Start) n_start++;
            if (bus.dp_Reset) n_rst++;
            check({tag, "/in_ready_busy"}, bus.in_ready, 1'b0);
            check({tag, "/dp_block"}, bus.dp_block, exp_dp);
            check({tag, "/dp_key"}, bus.dp_key, k);
            check({tag, "/dp_EnDe"}, bus.dp_EnDe, ed);
            @(posedge Clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/start_pulses"}, n_start, 1);
        check({tag, "/reset_pulses"}, n_rst, 1);
        check({tag, "/out_block"}, bus.out_block, exp_out);
        got = bus.out_block;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            check({tag, "/hold_valid"}, bus.out_valid, 1'b1);
            check({tag, "/hold_block"}, bus.out_block, exp_out);
            check({tag, "/hold_in_ready"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge Clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "/released_valid"}, bus.out_valid, 1'b0);
        check({tag, "/released_in_ready"}, bus.in_ready, 1'b1);
    endtask

    task automatic load_iv(input logic [127:0] v);
        bus.iv      = v;
        bus.iv_load = 1'b1;
        @(posedge Clk); #1;
        bus.iv_load = 1'b0;
`ifdef CBC_MODE_EN
        m_chain = v;
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] got;
        logic [127:0] v;
        Reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.key       = '0;
        bus.EnDe      = 1'b0;
        bus.iv        = '0;
        bus.iv_load   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        check("rst/in_ready", bus.in_ready, 1'b1);
        check("rst/out_valid", bus.out_valid, 1'b0);
        check("rst/dp_Start", bus.dp_Start, 1'b0);
        check("rst/dp_Reset", bus.dp_Reset, 1'b1);
        check("rst/out_block", bus.out_block, '0);
        check("rst/dp_block", bus.dp_block, '0);
        check("rst/dp_key", bus.dp_key, '0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rst/dp_Reset_released", bus.dp_Reset, 1'b0);

        // plain block with chain 0: F0 ^ key 01
        run_block(128'hF0, 128'h1, 1'b0, 0, 14, "ecb_vec", got);
        check("ecb_vec/const", got, 128'hF1);

`ifdef CBC_MODE_EN
        load_iv(128'hFF);
        run_block(128'h01, '0, 1'b0, 0, 14, "cbc_enc1", got);
        check("cbc_enc1/const", got, 128'hFE);
        run_block(128'h02, '0, 1'b0, 0, 14, "cbc_enc2", got);
        check("cbc_enc2/const", got, 128'hFC);
        load_iv(128'hFF);
        run_block(128'hFE, '0, 1'b1, 0, 14, "cbc_dec1", got);
        check("cbc_dec1/const", got, 128'h01);
        run_block(128'hFC, '0, 1'b1, 0, 14, "cbc_dec2", got);
        check("cbc_dec2/const", got, 128'h02);

        // iv_load colliding with in_valid: load wins, block waits a cycle
        v            = rnd128();
        bus.iv       = v;
        bus.iv_load  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_block = 128'h1234;
        #1;
        check("ivcol/in_ready_low", bus.in_ready, 1'b0);
        @(posedge Clk); #1;
        bus.iv_load = 1'b0;
        m_chain     = v;
        #1;
        check("ivcol/not_taken", bus.in_ready, 1'b1);
        check("ivcol/no_dp_reset", bus.dp_Reset, 1'b0);
        run_block(128'h1234, 128'h55, 1'b0, 0, 14, "ivcol_blk", got);
`else
        // ECB: iv_load must not block input
        bus.iv_load = 1'b1;
        bus.iv      = rnd128();
        #1;
        check("ecb_ivload/in_ready", bus.in_ready, 1'b1);
        run_block(128'h01, '0, 1'b0, 0, 14, "ecb_enc1", got);
        check("ecb_enc1/const", got, 128'h01);
        bus.iv_load = 1'b0;
        run_block(128'hFE, '0, 1'b1, 0, 14, "ecb_dec1", got);
        check("ecb_dec1/const", got, 128'hFE);
`endif

        // long backpressure
        run_block(rnd128(), rnd128(), 1'b0, 20, 14, "hold20", got);

        // reset in the middle of WAIT
        bus.in_valid = 1'b1;
        bus.in_block = rnd128();
        bus.key      = rnd128();
        bus.EnDe     = 1'b0;
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        check("midrst/busy_seen", bus.dp_busy, 1'b1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midrst/out_valid", bus.out_valid, 1'b0);
        check("midrst/in_ready", bus.in_ready, 1'b1);
        check("midrst/out_block", bus.out_block, '0);
        check("midrst/dp_block", bus.dp_block, '0);
        Reset   = 1'b0;
        m_chain = '0;
        @(posedge Clk); #1;
        run_block(128'hA5, 128'h3C, 1'b0, 0, 14, "after_rst", got);
        check("after_rst/const", got, 128'h99);

        // dead datapath: watchdog releases WAIT after 16 quiet cycles
        stub_dead = 1'b1;
        run_block(rnd128(), rnd128(), 1'b0, 0, 19, "watchdog", got);
        stub_dead = 1'b0;

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) load_iv(rnd128());
            run_block(rnd128(), rnd128(), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 14, "rand", got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/cbc_sequencer.md
CBC_SEQUENCER -- requirements
Module: cbc_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; all state updates on rising Clk.
REQ-002 Clk  in  1  clock.
REQ-003 Reset  in  1  synchronous, active-high; clears all state.
REQ-004 in_valid/in_ready  in/out  1/1  input block handshake; transfer when both are high on a rising edge.
REQ-005 in_block  in  128  plaintext (EnDe=0) or ciphertext (EnDe=1).
REQ-006 key  in  128  cipher key, latched on each input transfer.
REQ-007 EnDe  in  1  0=encrypt, 1=decrypt, latched on each input transfer.
REQ-008 iv  in  128; iv_load  in  1  loads the chain register.
REQ-009 out_valid/out_ready  out/in  1/1  result handshake; out_block  out  128  result.
REQ-010 dp_Reset, dp_Start, dp_EnDe  out  1  cipher datapath controls; dp_block, dp_key  out  128.
REQ-011 dp_o  in  128; dp_busy  in  1  datapath result and busy flag.

Function
REQ-012 SHALL implement FSM IDLE -> DP_RST -> DP_GO -> WAIT -> OUT -> IDLE.
REQ-013 IDLE: in_ready=1; on transfer, latch in_block, key and EnDe, then go to DP_RST.
REQ-014 DP_RST: dp_Reset=1 for exactly one cycle, then go to DP_GO.
REQ-015 DP_GO: dp_Start=1 for exactly one cycle, with dp_block, dp_key and dp_EnDe valid; then go to WAIT.
REQ-016 dp_block, dp_key and dp_EnDe SHALL be held stable from DP_GO until leaving WAIT.
REQ-017 WAIT: set seen_busy when dp_busy=1; complete on the first cycle with dp_busy=0 and seen_busy=1; on completion, register the result and go to OUT.
REQ-018 WAIT watchdog: 8-bit counter; if seen_busy is still 0 after 16 cycles, treat the next dp_busy=0 cycle as completion.
REQ-019 OUT: out_valid=1 and out_block stable until out_ready=1, then go to IDLE; in_ready=0 in every state except IDLE.
REQ-020 Throughput: at most one block in flight; input-to-out_valid latency = datapath busy cycles + 4.
REQ-021 iv_load in IDLE loads chain <= iv; if it coincides with in_valid, iv_load wins and the input is not accepted that cycle (in_ready=0); iv_load outside IDLE is ignored.
REQ-022 Backpressure: if out_ready is held low indefinitely, the FSM SHALL stay in OUT with no state change.
REQ-023 EnDe changing while not in IDLE SHALL have no effect on the block in flight.

Reset
REQ-024 On Reset: state=IDLE; in_ready=1; out_valid=0; dp_Start=0; dp_Reset=1 for the reset cycle.
REQ-025 On Reset: out_block, chain, dp_block and dp_key SHALL all be 0.
REQ-026 Reset mid-operation aborts the block in flight, discards its result and does not update chain.

Configuration
REQ-027 Macro CBC_MODE_EN SHALL select CBC chaining when defined.
REQ-028 With CBC_MODE_EN, encrypt: dp_block = in_block ^ chain, out_block = dp_o, chain <= dp_o.
REQ-029 With CBC_MODE_EN, decrypt: dp_block = in_block, out_block = dp_o ^ chain, chain <= latched in_block.
REQ-030 Without CBC_MODE_EN (ECB): dp_block = in_block and out_block = dp_o; chain, iv and iv_load are unused, and iv_load does not block input.

Verification
Bench datapath stub: o = block ^ key; busy rises 1 cycle after Start and is held for 10 cycles.
REQ-031 ECB: key=0...01, in_block=0...F0 -> out_block=0...F1; out_valid rises 14 cycles after the transfer.
REQ-032 CBC encrypt: iv=0...FF, key=0, blocks 0...01 then 0...02 -> out_block 0...FE, then 0...FC.
REQ-033 CBC decrypt: iv=0...FF, key=0, blocks 0...FE then 0...FC -> out_block 0...01, then 0...02.
REQ-034 Hold out_ready=0 for 20 cycles -> out_valid stays 1, out_block unchanged, in_ready=0; release -> in_ready=1 the next cycle.
REQ-035 Assert Reset during WAIT -> next cycle state=IDLE, out_valid=0, chain=0; the following block encrypts with chain=0.
REQ-036 Assert iv_load and in_valid together in IDLE -> chain=iv, no transfer that cycle; block is accepted the next cycle.
